iram_ctrl: RTL

IRAM_CTRL -- requirements
Module: iram_ctrl

---
 rtl/iram_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/iram_ctrl.sv
// rtl/iram_ctrl.sv - instruction RAM refill controller: fetches one cache line per miss, word by word.
// Optional line buffer replaying the last refilled line: define IRAM_CTRL_LINEBUF_EN.
module iram_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_cache,
  input  logic [ADDR_W-1:0] ram_address,
  output logic [WORD_W-1:0] mem_word,
  output logic              word_ready,
  output logic              busy,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_gnt,
  input  logic              ram_rvalid,
  input  logic [WORD_W-1:0] ram_rdata
);

  localparam int WORD_BYTES = WORD_W / 8;
  localparam int LINE_BYTES = LINE_WORDS * WORD_BYTES;
  localparam int KW         = $clog2(LINE_WORDS);
  localparam int WB         = $clog2(WORD_BYTES);
  localparam logic [KW-1:0]     K_LAST   = KW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, REPLAY} state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] miss_base;

  assign miss_base = ram_address & ~OFF_MASK;

  // Addition wraps naturally at the top of the address space.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [KW-1:0]     i);
    return b + (ADDR_W'(i) << WB);
  endfunction

`ifdef IRAM_CTRL_LINEBUF_EN
  logic [WORD_W-1:0] lb_data [LINE_WORDS];
  logic [ADDR_W-1:0] lb_tag;
  logic              lb_valid;

  always_ff @(posedge clk) begin
    if (state == WAIT && ram_rvalid)
      lb_data[k] <= ram_rdata;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      base       <= '0;
      ram_req    <= 1'b0;
      ram_addr   <= '0;
      word_ready <= 1'b0;
      busy       <= 1'b0;
      mem_word   <= '0;
`ifdef IRAM_CTRL_LINEBUF_EN
      lb_tag     <= '0;
      lb_valid   <= 1'b0;
`endif
    end else begin
      word_ready <= 1'b0;
      case (state)
        IDLE: begin
          k <= '0;
          if (miss_cache) begin
            base <= miss_base;
            busy <= 1'b1;
`ifdef IRAM_CTRL_LINEBUF_EN
            if (lb_valid && lb_tag == miss_base) begin
              mem_word   <= lb_data[0];
              word_ready <= 1'b1;
              k          <= KW'(1);
              state      <= REPLAY;
            end else begin
              // Buffer is overwritten by this refill; an abort must leave it invalid.
              lb_valid <= 1'b0;
              ram_req  <= 1'b1;
              ram_addr <= miss_base;
              state    <= REQ;
            end
`else
            ram_req  <= 1'b1;
            ram_addr <= miss_base;
            state    <= REQ;
`endif
          end
        end
        REQ: begin
          if (ram_gnt) begin
            ram_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (ram_rvalid) begin
            mem_word   <= ram_rdata;
            word_ready <= 1'b1;
            if (k == K_LAST) begin
              state <= DONE;
`ifdef IRAM_CTRL_LINEBUF_EN
              lb_valid <= 1'b1;
              lb_tag   <= base;
`endif
            end else begin
              k        <= k + KW'(1);
              ram_req  <= 1'b1;
              ram_addr <= word_addr(base, k + KW'(1));
              state    <= REQ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          k     <= '0;
          state <= IDLE;
        end
`ifdef IRAM_CTRL_LINEBUF_EN
        REPLAY: begin
          mem_word   <= lb_data[k];
          word_ready <= 1'b1;
          if (k == K_LAST) state <= DONE;
          else             k     <= k + KW'(1);
        end
`endif
        default: begin
          busy    <= 1'b0;
          ram_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
